// File: rtl/sram_mem_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : sram_mem_controller_pkg                                           |
// | Purpose : Shared definitions for the SRAM memory controller: FSM state      |
// |           encoding, default parameter values and half-word select bits.     |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package sram_mem_controller_pkg;

  localparam int unsigned DEF_DATA_LEN      = 32;
  localparam int unsigned DEF_SRAM_DATA_LEN = 16;
  localparam int unsigned DEF_SRAM_ADDR_LEN = 18;
  localparam int unsigned DEF_DATA_BASE     = 1024;
  localparam int unsigned DEF_WAIT_CYCLES   = 5;

  // Appended as the LSB of the SRAM half-word address.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  function automatic logic is_hi_phase(input state_e s);
    return (s == S_RD_HI) || (s == S_WR_HI);
  endfunction

  function automatic logic is_wr_phase(input state_e s);
    return (s == S_WR_LO) || (s == S_WR_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_mem_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: sram_mem_controller_if                                           |
// | Purpose  : Memory-stage request bus between the pipeline and the SRAM       |
// |            controller.                                                      |
// | Signals  : mem_r_en / mem_w_en  level load/store requests (held until ready)|
// |            alu_res              byte address                                |
// |            val_rm               store data                                  |
// |            ready                0 = freeze pipeline                         |
// |            mem_out              load result                                 |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface sram_mem_controller_if #(
  parameter int unsigned DATA_LEN = 32
) ();

  logic                mem_r_en;
  logic                mem_w_en;
  logic [DATA_LEN-1:0] alu_res;
  logic [DATA_LEN-1:0] val_rm;
  logic                ready;
  logic [DATA_LEN-1:0] mem_out;

  modport master (
    output mem_r_en, mem_w_en, alu_res, val_rm,
    input  ready, mem_out
  );

  modport slave (
    input  mem_r_en, mem_w_en, alu_res, val_rm,
    output ready, mem_out
  );

endinterface
`default_nettype wire

// File: rtl/sram_mem_controller_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sram_mem_controller_wait_counter                                  |
// | Purpose : Modulo-MODULUS phase timer with synchronous clear and enable.     |
// | Ports   : clk, rst_n  clock / async active-low reset                        |
// |           clr_i       force count to 0 (wins over en_i)                     |
// |           en_i        advance count, wrapping to 0 after MODULUS-1          |
// |           tc_o        count == MODULUS-1                                    |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module sram_mem_controller_wait_counter #(
  parameter int unsigned MODULUS = 5
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr_i,
  input  wire logic en_i,
  output logic      tc_o
);

  localparam int unsigned CW = (MODULUS > 1) ? $clog2(MODULUS) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc_o = (count_q == CW'(MODULUS - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_mem_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sram_mem_controller                                               |
// | Purpose : Sequences 32-bit memory-stage loads/stores onto a 16-bit async    |
// |           SRAM as two half-word phases of WAIT_CYCLES cycles each.          |
// | Ports   : clk, rst_n        clock / async active-low reset                  |
// |           bus (slave)       pipeline request bus, ready = ~freeze           |
// |           sram_addr_o       half-word address                               |
// |           sram_dq_out_o     write data to pad                               |
// |           sram_dq_oe_o      1 = drive pad                                   |
// |           sram_dq_in_i      read data from pad                              |
// |           sram_we_n_o       active-low write strobe                         |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned DATA_LEN      = DEF_DATA_LEN,
  parameter int unsigned SRAM_DATA_LEN = DEF_SRAM_DATA_LEN,
  parameter int unsigned SRAM_ADDR_LEN = DEF_SRAM_ADDR_LEN,
  parameter int unsigned DATA_BASE     = DEF_DATA_BASE,
  parameter int unsigned WAIT_CYCLES   = DEF_WAIT_CYCLES
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  sram_mem_controller_if.slave          bus,
  output logic [SRAM_ADDR_LEN-1:0]      sram_addr_o,
  output logic [SRAM_DATA_LEN-1:0]      sram_dq_out_o,
  output logic                          sram_dq_oe_o,
  input  wire logic [SRAM_DATA_LEN-1:0] sram_dq_in_i,
  output logic                          sram_we_n_o
);

  localparam int unsigned WORD_W = SRAM_ADDR_LEN - 1;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic [DATA_LEN-1:0] mem_out_q, mem_out_d;

  logic                w_ready;
  logic                w_cnt_en;
  logic                w_tc;
  logic                w_hi;
  logic                w_wr;
  logic [WORD_W-1:0]   w_req_word;

  // Offset from the data base wraps mod 2^DATA_LEN, then the word index is
  // truncated to the SRAM's word address range.
  assign w_req_word = WORD_W'((bus.alu_res - DATA_LEN'(DATA_BASE)) >> 2);

  sram_mem_controller_wait_counter #(
    .MODULUS (WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (~w_cnt_en),
    .en_i  (w_cnt_en),
    .tc_o  (w_tc)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    data_d    = data_q;
    mem_out_d = mem_out_q;
    w_ready   = 1'b0;
    w_cnt_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        w_ready = ~(bus.mem_r_en | bus.mem_w_en);
        // Store has priority when both enables are raised.
        if (bus.mem_w_en) begin
          state_d = S_WR_LO;
          word_d  = w_req_word;
          data_d  = bus.val_rm;
        end else if (bus.mem_r_en) begin
          state_d = S_RD_LO;
          word_d  = w_req_word;
        end
      end
      S_RD_LO: begin
        w_cnt_en = 1'b1;
        if (w_tc) begin
          mem_out_d[SRAM_DATA_LEN-1:0] = sram_dq_in_i;
          state_d                      = S_RD_HI;
        end
      end
      S_RD_HI: begin
        w_cnt_en = 1'b1;
        if (w_tc) begin
          mem_out_d[DATA_LEN-1:SRAM_DATA_LEN] = sram_dq_in_i;
          state_d                             = S_DONE;
        end
      end
      S_WR_LO: begin
        w_cnt_en = 1'b1;
        if (w_tc) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        w_cnt_en = 1'b1;
        if (w_tc) state_d = S_DONE;
      end
      S_DONE: begin
        w_ready = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      data_q    <= '0;
      mem_out_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      data_q    <= data_d;
      mem_out_q <= mem_out_d;
    end
  end

  assign w_hi = is_hi_phase(state_q);
  assign w_wr = is_wr_phase(state_q);

  // Pin outputs decode registered state only, so reset forces them at once.
  // WE_N rises on the phase's last cycle to give address/data hold time.
  assign sram_addr_o   = {word_q, (w_hi ? HALF_HI : HALF_LO)};
  assign sram_dq_out_o = w_hi ? data_q[DATA_LEN-1:SRAM_DATA_LEN] : data_q[SRAM_DATA_LEN-1:0];
  assign sram_dq_oe_o  = w_wr;
  assign sram_we_n_o   = ~(w_wr & ~w_tc);

  assign bus.ready   = w_ready;
  assign bus.mem_out = mem_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sram_mem_controller                                            |
// | Purpose : Self-checking bench for sram_mem_controller with a behavioural    |
// |           SRAM array and a word-level reference memory.                     |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sram_mem_controller;

  localparam int WC  = 5;
  localparam int LAT = 1 + 2 * WC;

  logic        clk;
  logic        rst_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  sram_mem_controller_if #(.DATA_LEN(32)) bus ();

  sram_mem_controller #(
    .DATA_LEN      (32),
    .SRAM_DATA_LEN (16),
    .SRAM_ADDR_LEN (18),
    .DATA_BASE     (1024),
    .WAIT_CYCLES   (WC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .sram_addr_o   (sram_addr),
    .sram_dq_out_o (sram_dq_out),
    .sram_dq_oe_o  (sram_dq_oe),
    .sram_dq_in_i  (sram_dq_in),
    .sram_we_n_o   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM (small window is enough for the test addresses).
  logic [15:0] sram [0:511];
  assign sram_dq_in = sram[sram_addr[8:0]];
  always @(posedge clk) begin
    if (!sram_we_n) sram[sram_addr[8:0]] <= sram_dq_out;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin-activity monitor for the access in flight.
  bit          mon_en = 1'b0;
  logic [16:0] mon_word;
  logic [31:0] mon_data;
  int mon_lo, mon_hi, mon_bad, mon_we, mon_oe;
  always @(negedge clk) begin
    if (mon_en) begin
      if (sram_dq_oe) mon_oe++;
      if (!sram_we_n) begin
        mon_we++;
        if (sram_addr == {mon_word, 1'b0} && sram_dq_out == mon_data[15:0]) mon_lo++;
        else if (sram_addr == {mon_word, 1'b1} && sram_dq_out == mon_data[31:16]) mon_hi++;
        else mon_bad++;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request after the next posedge and waits for its DONE cycle.
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input bit rel, output logic [31:0] rd, output int done_cyc);
    int lat;
    logic [31:0] off;
    @(posedge clk); #1;
    off      = a - 32'd1024;
    mon_word = off[18:2];
    mon_data = d;
    mon_lo = 0; mon_hi = 0; mon_bad = 0; mon_we = 0; mon_oe = 0;
    mon_en = 1'b1;
    bus.mem_w_en = w;
    bus.mem_r_en = r;
    bus.alu_res  = a;
    bus.val_rm   = d;
    lat = 0;
    @(negedge clk);
    while (!bus.ready && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    rd       = bus.mem_out;
    done_cyc = cyc;
    mon_en   = 1'b0;
    chk("latency", lat, LAT);
    if (w) begin
      chk("we_lo_cycles", mon_lo, WC - 1);
      chk("we_hi_cycles", mon_hi, WC - 1);
      chk("we_bad_pins", mon_bad, 0);
      chk("oe_write_cycles", mon_oe, 2 * WC);
    end else begin
      chk("read_we_cycles", mon_we, 0);
      chk("read_oe_cycles", mon_oe, 0);
    end
    if (rel) begin
      @(posedge clk); #1;
      bus.mem_w_en = 1'b0;
      bus.mem_r_en = 1'b0;
    end
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_out;
  } vec_t;

  vec_t        vt [7];
  logic [31:0] ref_mem [int];
  logic [31:0] last_load;
  logic [31:0] rd, exp, a, d, off;
  int          c1, c2, idx;
  bit          rw, rr;

  initial begin
    for (int i = 0; i < 512; i++) sram[i] = 16'h0000;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.alu_res  = '0;
    bus.val_rm   = '0;
    rst_n = 1'b0;

    vt[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000};
    vt[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b0, 32'd1032, 32'h12345678, 32'hDEADBEEF};
    vt[3] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'h12345678};
    vt[4] = '{1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 32'h12345678};
    vt[5] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hCAFEF00D};
    vt[6] = '{1'b0, 1'b1, 32'd1035, 32'h0,        32'h12345678};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_oe", sram_dq_oe, 1'b0);
    chk("rst_mem_out", bus.mem_out, 32'h0);
    chk("rst_addr", sram_addr, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet bus: enables low must produce no SRAM activity and no freeze.
    mon_we = 0; mon_oe = 0; c1 = 0;
    mon_word = '1; mon_data = '0; mon_en = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (!bus.ready) c1++;
    end
    mon_en = 1'b0;
    chk("idle_we", mon_we, 0);
    chk("idle_oe", mon_oe, 0);
    chk("idle_ready_low", c1, 0);

    last_load = 32'h0;
    for (int i = 0; i < 7; i++) begin
      access(vt[i].w, vt[i].r, vt[i].addr, vt[i].data, 1'b1, rd, c1);
      chk($sformatf("vec%0d_mem_out", i), rd, vt[i].exp_out);
      off = vt[i].addr - 32'd1024;
      if (vt[i].w) ref_mem[int'(off[18:2])] = vt[i].data;
      else last_load = vt[i].exp_out;
    end
    chk("both_en_sram_lo", {16'h0, sram[0]}, 32'h0000F00D);
    chk("both_en_sram_hi", {16'h0, sram[1]}, 32'h0000CAFE);

    // Back-to-back: store held straight into a load with no idle gap.
    d = $urandom;
    access(1'b1, 1'b0, 32'd1100, d, 1'b0, rd, c1);
    access(1'b0, 1'b1, 32'd1100, 32'h0, 1'b1, rd, c2);
    chk("b2b_spacing", c2 - c1, LAT + 1);
    chk("b2b_load", rd, d);
    ref_mem[19] = d;
    last_load = d;

    // Randomized traffic against the word-level reference memory.
    for (int i = 0; i < 40; i++) begin
      rw  = 1'($urandom_range(0, 1));
      rr  = rw ? 1'($urandom_range(0, 1)) : 1'b1;
      idx = $urandom_range(0, 63);
      a   = 32'd1024 + 32'(idx * 4) + 32'($urandom_range(0, 3));
      d   = $urandom;
      access(rw, rr, a, d, 1'b1, rd, c1);
      if (rw) begin
        ref_mem[idx] = d;
        chk("rand_store_hold", rd, last_load);
      end else begin
        exp = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        chk("rand_load", rd, exp);
        last_load = exp;
      end
    end

    // Reset in the middle of WR_HI (count 3).
    @(posedge clk); #1;
    bus.mem_w_en = 1'b1;
    bus.alu_res  = 32'd1024;
    bus.val_rm   = 32'h11112222;
    repeat (1 + WC + 3) @(posedge clk);
    #1;
    chk("abort_in_wr_hi_addr", sram_addr, 18'd1);
    chk("abort_in_wr_hi_we_n", sram_we_n, 1'b0);
    rst_n = 1'b0;
    bus.mem_w_en = 1'b0;
    #1;
    chk("abort_addr", sram_addr, 18'd0);
    chk("abort_we_n", sram_we_n, 1'b1);
    chk("abort_oe", sram_dq_oe, 1'b0);
    chk("abort_dq_out", sram_dq_out, 16'h0);
    chk("abort_ready", bus.ready, 1'b1);
    chk("abort_mem_out", bus.mem_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 32'd1024, 32'hA5A55A5A, 1'b1, rd, c1);
    chk("post_rst_store_hold", rd, 32'h0);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, rd, c1);
    chk("post_rst_load", rd, 32'hA5A55A5A);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1, rd, c1);
    exp = ref_mem.exists(1) ? ref_mem[1] : 32'h0;
    chk("post_rst_load_other", rd, exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
